// File: rtl/gnrl_skid_buf.sv
// Two-entry registered skid buffer for a valid/ready handshake.
// o_vld, i_rdy and o_dat come straight from flops, so no combinational path crosses the buffer.
module gnrl_skid_buf #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          i_vld,
   output logic          i_rdy,
   input  logic [DW-1:0] i_dat,
   output logic          o_vld,
   input  logic          o_rdy,
   output logic [DW-1:0] o_dat,
   output logic [1:0]    cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] main_q, main_d;
   logic [DW-1:0] skid_q, skid_d;
   logic          in_fire;
   logic          out_fire;

   assign o_vld    = (state_q != EMPTY);
   assign i_rdy    = (state_q != FULL);
   assign o_dat    = main_q;
   assign in_fire  = i_vld & i_rdy;
   assign out_fire = o_vld & o_rdy;

   always_comb begin
      cnt = 2'd0;
      case (state_q)
         BUSY:    cnt = 2'd1;
         FULL:    cnt = 2'd2;
         default: cnt = 2'd0;
      endcase
   end

   // Flush only redirects the state; the data registers keep whatever they held.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_d  = i_dat;
                  state_d = BUSY;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  main_d = i_dat;
               end else if (in_fire) begin
                  skid_d  = i_dat;
                  state_d = FULL;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = BUSY;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_gnrl_skid_buf.sv
// Self-checking bench for gnrl_skid_buf: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_gnrl_skid_buf;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          i_vld;
   logic          i_rdy;
   logic [DW-1:0] i_dat;
   logic          o_vld;
   logic          o_rdy;
   logic [DW-1:0] o_dat;
   logic [1:0]    cnt;

   int checks = 0;
   int errors = 0;

   gnrl_skid_buf #(.DW(DW)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .i_vld (i_vld),
      .i_rdy (i_rdy),
      .i_dat (i_dat),
      .o_vld (o_vld),
      .o_rdy (o_rdy),
      .o_dat (o_dat),
      .cnt   (cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        flush;
      logic        vld;
      logic [31:0] dat;
      logic        rdy;
      logic        exp_vld;
      logic        exp_irdy;
      logic [1:0]  exp_cnt;
      logic [31:0] exp_dat;
      logic        chk_dat;
   } vec_t;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge.
   task automatic applyStimulus(input logic f, input logic v, input logic [31:0] d, input logic r);
      flush = f;
      i_vld = v;
      i_dat = d;
      o_rdy = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkAll(input string tag, input logic ev, input logic er, input logic [1:0] ec,
                           input logic [31:0] ed, input logic cd);
      checkOutput({tag, ".o_vld"}, 32'(o_vld), 32'(ev));
      checkOutput({tag, ".i_rdy"}, 32'(i_rdy), 32'(er));
      checkOutput({tag, ".cnt"},   32'(cnt),   32'(ec));
      if (cd) checkOutput({tag, ".o_dat"}, o_dat, ed);
   endtask

   vec_t          vecs[14];
   logic [31:0]   mq[$];
   logic          m_in_fire, m_out_fire;
   logic          prev_vld, prev_out_fire, prev_flush;
   logic          hold;
   logic [31:0]   hold_dat;

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA5A5_0001, 1'b1};
      vecs[1]  = '{1'b0, 1'b1, 32'hA5A5_0002, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA5A5_0001, 1'b1};
      vecs[2]  = '{1'b0, 1'b1, 32'hA5A5_0003, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA5A5_0001, 1'b1};
      vecs[3]  = '{1'b0, 1'b1, 32'hA5A5_0003, 1'b1, 1'b1, 1'b1, 2'd1, 32'hA5A5_0002, 1'b1};
      vecs[4]  = '{1'b0, 1'b1, 32'hA5A5_0003, 1'b1, 1'b1, 1'b1, 2'd1, 32'hA5A5_0003, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 2'd0, 32'h0,         1'b0};
      vecs[6]  = '{1'b0, 1'b1, 32'h11,        1'b0, 1'b1, 1'b1, 2'd1, 32'h11,        1'b1};
      vecs[7]  = '{1'b0, 1'b1, 32'h22,        1'b1, 1'b1, 1'b1, 2'd1, 32'h22,        1'b1};
      vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 2'd0, 32'h0,         1'b0};
      vecs[9]  = '{1'b0, 1'b1, 32'h55,        1'b0, 1'b1, 1'b1, 2'd1, 32'h55,        1'b1};
      vecs[10] = '{1'b0, 1'b1, 32'h66,        1'b0, 1'b1, 1'b0, 2'd2, 32'h55,        1'b1};
      vecs[11] = '{1'b1, 1'b1, 32'h33,        1'b0, 1'b0, 1'b1, 2'd0, 32'h0,         1'b0};
      vecs[12] = '{1'b0, 1'b1, 32'h44,        1'b0, 1'b1, 1'b1, 2'd1, 32'h44,        1'b1};
      vecs[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 2'd0, 32'h0,         1'b0};

      rst   = 1'b1;
      flush = 1'b0;
      i_vld = 1'b0;
      i_dat = '0;
      o_rdy = 1'b0;
      repeat (2) @(negedge clk);
      checkAll("reset", 1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
      rst = 1'b0;

      // Backpressure, simultaneous in/out and flush-in-FULL vectors.
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].flush, vecs[i].vld, vecs[i].dat, vecs[i].rdy);
         checkAll($sformatf("vec%0d", i), vecs[i].exp_vld, vecs[i].exp_irdy, vecs[i].exp_cnt,
                  vecs[i].exp_dat, vecs[i].chk_dat);
      end

      // Asynchronous reset while FULL, observed before any clock edge.
      applyStimulus(1'b0, 1'b1, 32'hBEEF_0001, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'hBEEF_0002, 1'b0);
      checkAll("prefull", 1'b1, 1'b0, 2'd2, 32'hBEEF_0001, 1'b1);
      i_vld = 1'b0;
      #2 rst = 1'b1;
      #1 checkAll("async_rst", 1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      // Streaming at full rate with one-cycle latency.
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1'b0, 1'b1, 32'(i), 1'b1);
         checkAll($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 32'(i), 1'b1);
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkAll("stream_end", 1'b0, 1'b1, 2'd0, 32'h0, 1'b0);

      // Random traffic against a plain FIFO-of-two model.
      mq.delete();
      hold = 1'b0;
      hold_dat = '0;
      prev_vld = o_vld;
      prev_out_fire = 1'b0;
      prev_flush = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         flush = ($urandom_range(0, 31) == 0);
         o_rdy = $urandom_range(0, 1);
         if (hold) begin
            i_vld = 1'b1;
            i_dat = hold_dat;
         end else begin
            i_vld = $urandom_range(0, 1);
            i_dat = $urandom;
         end
         m_in_fire  = i_vld && (mq.size() < 2);
         m_out_fire = o_rdy && (mq.size() > 0);
         prev_vld      = o_vld;
         prev_out_fire = o_vld && o_rdy;
         prev_flush    = flush;
         @(posedge clk);
         if (flush) begin
            mq.delete();
         end else begin
            if (m_out_fire) void'(mq.pop_front());
            if (m_in_fire)  mq.push_back(i_dat);
         end
         hold     = i_vld && !m_in_fire && !flush;
         hold_dat = i_dat;
         @(negedge clk);
         if (o_vld !== (mq.size() > 0) || i_rdy !== (mq.size() < 2) || cnt !== 2'(mq.size())) begin
            checkOutput($sformatf("rand%0d.ctrl", c), {29'b0, o_vld, cnt}, {29'b0, mq.size() > 0, 2'(mq.size())});
            checkOutput($sformatf("rand%0d.i_rdy", c), 32'(i_rdy), 32'(mq.size() < 2));
         end else begin
            checks++;
         end
         if (mq.size() > 0) checkOutput($sformatf("rand%0d.o_dat", c), o_dat, mq[0]);
         checkOutput($sformatf("rand%0d.cnt_le2", c), 32'(cnt > 2'd2), 32'd0);
         checkOutput($sformatf("rand%0d.vld_drop", c),
                     32'(prev_vld && !o_vld && !prev_out_fire && !prev_flush), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
